// File: rtl/suma_serial.sv
// Bit-serial reconstruction adder: A = B + RES (Sign=1) or B - RES (Sign=0), one bit per clock.
// Optional range-error flag enabled by defining SUMA_SERIAL_ERR_EN.
module suma_serial #(
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [P-1:0] B,
  input  logic [P-1:0] RES,
  input  logic         Sign,
  output logic [P-1:0] A,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int CW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg;
  logic [P-1:0]   sb_reg;
  logic [P-1:0]   sr_reg;
  logic [P-1:0]   a_reg;
  logic [CW-1:0]  cnt_reg;
  logic           sub_reg;
  logic           c_reg;
  logic           busy_reg;
  logic           done_reg;

  logic           y;
  logic           s;
  logic           c_next;
  logic           last;

  // Single full-adder slice; subtraction inverts RES and preloads carry with 1.
  assign y      = sr_reg[0] ^ sub_reg;
  assign s      = sb_reg[0] ^ y ^ c_reg;
  assign c_next = (sb_reg[0] & y) | (sb_reg[0] & c_reg) | (y & c_reg);
  assign last   = (cnt_reg == CW'(P - 1));

`ifdef SUMA_SERIAL_ERR_EN
  logic err_reg;
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sb_reg    <= '0;
      sr_reg    <= '0;
      a_reg     <= '0;
      cnt_reg   <= '0;
      sub_reg   <= 1'b0;
      c_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SUMA_SERIAL_ERR_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            sb_reg    <= B;
            sr_reg    <= RES;
            sub_reg   <= ~Sign;
            c_reg     <= ~Sign;
            cnt_reg   <= '0;
            a_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          // LSB is produced first and walks down to bit 0 after P shifts.
          a_reg   <= {s, a_reg[P-1:1]};
          sb_reg  <= sb_reg >> 1;
          sr_reg  <= sr_reg >> 1;
          c_reg   <= c_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
`ifdef SUMA_SERIAL_ERR_EN
            // Add: carry-out is overflow. Subtract: missing carry is a borrow.
            err_reg   <= c_next ^ sub_reg;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign A    = a_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_suma_serial.sv
// Self-checking bench for suma_serial (P=4): directed and random operations against an arithmetic model.
module tb_suma_serial;

  localparam int P = 4;
`ifdef SUMA_SERIAL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [P-1:0] B;
  logic [P-1:0] RES;
  logic         Sign;
  logic [P-1:0] A;
  logic         busy;
  logic         done;
  logic         err;

  int errors = 0;
  int checks = 0;
  logic [P-1:0] last_a;
  logic         last_err;

  suma_serial #(.P(P)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .B     (B),
    .RES   (RES),
    .Sign  (Sign),
    .A     (A),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [P-1:0] model_a(input int b, input int r, input bit sg);
    int full;
    full = sg ? (b + r) : (b - r + (1 << P));
    return full[P-1:0];
  endfunction

  function automatic logic model_err(input int b, input int r, input bit sg);
    if (!ERR_EN) return 1'b0;
    return sg ? ((b + r) >= (1 << P)) : (r > b);
  endfunction

  // Issue one operation; if hold, keep start high and scramble inputs during RUN.
  task automatic run_op(input logic [P-1:0] b, input logic [P-1:0] r, input logic sg, input bit hold);
    logic [P-1:0] ea;
    logic         ee;
    ea = model_a(int'(b), int'(r), sg);
    ee = model_err(int'(b), int'(r), sg);
    B = b; RES = r; Sign = sg; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("busy_accept", busy, 1);
    check("done_accept", done, 0);
    for (int i = 1; i < P; i++) begin
      if (hold) begin
        B = P'($urandom); RES = P'($urandom); Sign = 1'($urandom);
      end
      @(posedge clk); #1;
      check("busy_run", busy, 1);
      check("done_run", done, 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("a_result", A, ea);
    check("err_result", err, ee);
    $display("op B=%0d RES=%0d Sign=%0d hold=%0d -> A=%0d err=%0d (exp A=%0d err=%0d)",
             b, r, sg, hold, A, err, ea, ee);
    last_a   = ea;
    last_err = ee;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_idle", done, 0);
    check("busy_idle", busy, 0);
    check("a_hold", A, last_a);
    check("err_hold", err, last_err);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; B = '0; RES = '0; Sign = 1'b0;
    last_a = '0; last_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", A, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(4'd3, 4'd4, 1'b1, 1'b0);
    idle_cycle();
    run_op(4'd9, 4'd4, 1'b0, 1'b0);
    idle_cycle();
    run_op(4'd6, 4'd0, 1'b0, 1'b0);
    run_op(4'd2, 4'd5, 1'b0, 1'b0);   // back-to-back from DONE
    idle_cycle();
    run_op(4'd5, 4'd10, 1'b1, 1'b1);  // start held, inputs churn during RUN
    idle_cycle();
    run_op(4'd12, 4'd6, 1'b1, 1'b0);  // leaves err set before reset test

    // Reset in the second RUN cycle of an op whose first result bit is 1.
    B = 4'd1; RES = 4'd0; Sign = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_a", A, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    $display("reset mid-op -> A=%0d busy=%0d done=%0d err=%0d", A, busy, done, err);
    rst = 1'b0;
    last_a = '0; last_err = 1'b0;
    idle_cycle();
    run_op(4'd1, 4'd1, 1'b1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) idle_cycle();
      run_op(P'($urandom), P'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
